// File: rtl/core_sequencer_if.sv
// Memory-side handshake bundle for core_sequencer: instruction fetch and data access.
interface core_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        inst_latch_en;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;

    modport master (
        output imem_req, imem_addr, inst_latch_en, dmem_req, dmem_we,
        input  imem_ack, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr, inst_latch_en, dmem_req, dmem_we,
        output imem_ack, dmem_ack
    );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle RV32I control sequencer: owns the PC and steps FETCH/DECODE/EXEC/MEM/WB.
// Optional retired-instruction counter enabled by defining SEQ_INSTRET_EN.
module core_sequencer #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              halt_req,
    core_sequencer_if.master  bus,
    input  logic [6:0]        opcode,
    input  logic [31:0]       imm,
    input  logic [31:0]       rs1_data,
    input  logic              reg_write_in,
    input  logic              branch,
    input  logic              jump,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              br_taken,
    output logic              reg_write_en,
    output logic [31:0]       pc,
    output logic              busy,
    output logic              halted,
    output logic              misalign,
    output logic [31:0]       instret
);
    localparam logic [6:0] OP_JALR = 7'b1100111;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t      state;
    logic        br_taken_q;
    logic        halt_pend;
    logic        imem_req_q;
    logic        dmem_req_q;
    logic [31:0] target;
    logic        target_bad;

    always_comb begin
        target = pc + 32'd4;
        if (jump && opcode == OP_JALR)
            target = (rs1_data + imm) & ~32'h1;
        else if (jump || (branch && br_taken_q))
            target = pc + imm;
    end
    assign target_bad = |target[1:0];

    // Request/status flags are registered from the next-state decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            pc         <= RESET_ADDR;
            br_taken_q <= 1'b0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            busy       <= 1'b0;
            halted     <= 1'b0;
            misalign   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    state      <= S_FETCH;
                    imem_req_q <= 1'b1;
                    busy       <= 1'b1;
                end
                S_FETCH: if (bus.imem_ack) begin
                    state      <= S_DECODE;
                    imem_req_q <= 1'b0;
                end
                S_DECODE: state <= S_EXEC;
                S_EXEC: begin
                    br_taken_q <= br_taken;
                    if (mem_read || mem_write) begin
                        state      <= S_MEM;
                        dmem_req_q <= 1'b1;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: if (bus.dmem_ack) begin
                    state      <= S_WB;
                    dmem_req_q <= 1'b0;
                end
                S_WB: begin
                    if (target_bad) begin
                        state    <= S_HALT;
                        misalign <= 1'b1;
                        busy     <= 1'b0;
                        halted   <= 1'b1;
                    end else begin
                        pc <= target;
                        if (halt_pend) begin
                            state  <= S_HALT;
                            busy   <= 1'b0;
                            halted <= 1'b1;
                        end else begin
                            state      <= S_FETCH;
                            imem_req_q <= 1'b1;
                        end
                    end
                end
                S_HALT: if (start) begin
                    state      <= S_FETCH;
                    imem_req_q <= 1'b1;
                    busy       <= 1'b1;
                    halted     <= 1'b0;
                    misalign   <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // A halt request arriving in WB itself still gets honoured at the next WB.
    always_ff @(posedge clk) begin
        if (rst)
            halt_pend <= 1'b0;
        else if (state == S_HALT && start)
            halt_pend <= 1'b0;
        else if (halt_req)
            halt_pend <= 1'b1;
        else if (state == S_WB)
            halt_pend <= 1'b0;
    end

    assign bus.imem_req      = imem_req_q;
    assign bus.imem_addr     = pc;
    assign bus.inst_latch_en = (state == S_FETCH) && bus.imem_ack;
    assign bus.dmem_req      = dmem_req_q;
    assign bus.dmem_we       = dmem_req_q && mem_write;
    assign reg_write_en      = (state == S_WB) && reg_write_in;

`ifdef SEQ_INSTRET_EN
    logic [31:0] instret_q;
    always_ff @(posedge clk) begin
        if (rst)
            instret_q <= 32'h0;
        else if (state == S_WB)
            instret_q <= instret_q + 32'd1;
    end
    assign instret = instret_q;
`else
    assign instret = 32'h0;
`endif
endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control sequencer for the RV32I single-cycle datapath. It owns the program counter and steps each instruction through fetch, decode, execute, optional memory access and write-back. It handshakes with instruction and data memory, and gates the register-file write enable so each instruction commits exactly once. It sits between the top level and the decoder/controller/ALU, and replaces the externally driven instruction address.

## Interface

- RESET_ADDR, 32'h0000_0000, PC value loaded on reset.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  leave IDLE/HALT and begin fetching.
- halt_req  in  1  request halt after the current instruction retires; latched.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  32  fetch address, equal to pc.
- imem_ack  in  1  instruction valid this cycle.
- inst_latch_en  out  1  one-cycle pulse that loads the instruction register.
- opcode  in  7  from the decoder.
- imm  in  32  sign-extended immediate from the decoder.
- rs1_data  in  32  register-file read port 1, used as the JALR base.
- reg_write_in, branch, jump, mem_read, mem_write  in  1 each  from the controller.
- br_taken  in  1  ALU comparator outcome.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write strobe.
- dmem_ack  in  1  data access complete.
- reg_write_en  out  1  gated register-file write enable.
- pc  out  32  current PC.
- busy  out  1  high in every state except IDLE and HALT.
- halted  out  1  high in HALT.
- misalign  out  1  sticky flag: halted on a misaligned target.
- instret  out  32  retired-instruction count (see Configuration).

## Operation

- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE:
  - start → FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - imem_ack → inst_latch_en=1 in the same cycle, then DECODE.
  - Otherwise hold; imem_req stays high until ack.
- DECODE → EXEC, unconditionally.
- EXEC:
  - Sample br_taken into an internal register.
  - mem_read|mem_write → MEM, else → WB.
- MEM:
  - dmem_req=1, dmem_we=mem_write.
  - dmem_ack → WB; otherwise hold with the request held.
- WB:
  - reg_write_en=reg_write_in for exactly this one cycle.
  - Next-PC rules:
    - jump && opcode==7'b1100111 (JALR): (rs1_data+imm) & ~32'h1.
    - jump (JAL): pc+imm.
    - branch && taken: pc+imm.
    - Otherwise: pc+4.
  - All sums are 32-bit, mod 2^32 (wrap-around, no flag).
  - Target[1:0]≠0 → pc unchanged, misalign=1, → HALT. The instruction's register write still commits.
  - Else pc←target; halt pending → HALT, else → FETCH.
- HALT:
  - start → FETCH; clears halt pending and misalign.
- halt_req is latched into halt pending in any state and honoured only at WB.
- start while busy is ignored.
- start and halt_req together in IDLE: go to FETCH, execute one instruction, then HALT.
- imem_ack outside FETCH and dmem_ack outside MEM are ignored.

## Timing

- Reset values:
  - State IDLE, pc=RESET_ADDR.
  - imem_req, dmem_req, dmem_we, inst_latch_en, reg_write_en, busy, halted, misalign all 0.
  - instret=0; halt pending cleared.
- rst has priority over every input. Mid-operation it aborts any outstanding request; the request deasserts the cycle after the reset edge, and no write-back occurs.
- Latency with zero-wait memory: 4 cycles per instruction, 5 with a data access. Each wait cycle adds 1.
- pc updates on the clock edge that leaves WB. The next FETCH presents the new address immediately.
- All outputs are registered state decodes or direct combinational functions of state plus the listed inputs. There is no combinational path from imem_ack to imem_addr.

## Configuration

- SEQ_INSTRET_EN defined:
  - instret increments by 1 on each WB exit, including a misaligned-halt exit.
  - Wraps 32'hFFFF_FFFF → 0; cleared only by rst.
- Undefined: instret is tied to 32'h0 and no counter flops are synthesized.

## Test plan

- Reset, then start with imem_ack held high and an ALU-type instruction → state sequence FETCH, DECODE, EXEC, WB; reg_write_en pulses exactly once; pc goes 0→4; next fetch address 4.
- Branch at pc=32'h10, imm=-8, br_taken=1 → pc=32'h08. Same with br_taken=0 → pc=32'h14.
- JALR with rs1_data=32'h103, imm=0 → pc=32'h102 → misalign=1, halted=1, pc stays at the JALR address.
- Load with dmem_ack delayed 3 cycles → dmem_req high for 4 cycles, dmem_we=0, instruction total 8 cycles, single reg_write_en.
- halt_req pulsed during DECODE → current instruction retires (instret+1 with SEQ_INSTRET_EN), then HALT; start resumes fetch at the updated pc.
- rst asserted mid-MEM with dmem_req=1 → next cycle dmem_req=0, pc=RESET_ADDR, state IDLE, reg_write_en never asserted.
